// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with valid/ready
// on both sides, per-stage hazard stall/flush, and a saturating flush-drop counter.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         stall,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW-1:0]    rd_ptr_nxt, wr_ptr_nxt;
  logic             push, pop;
  logic [SW-1:0]    drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  // in_ready depends only on registered occupancy and stall, never on out_ready
  assign in_ready  = (count < CW'(DEPTH)) && !stall;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !stall;

  // Explicit wrap compare so non-power-of-two DEPTH works
  assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
  assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

  always_comb begin
    drop_sum = SW'(drop_cnt) + SW'(count);
    drop_nxt = drop_sum[CNT_W-1:0];
    if (drop_sum > SW'({CNT_W{1'b1}})) begin
      drop_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= drop_nxt;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, DEPTH 3, CNT_W 2) share
// one stimulus stream and are checked every step against queue-based models.
module tb_pipe_stage_buf;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       stall;
  logic       flush;

  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];
  logic [1:0] cn [3];
  logic [15:0] dc0, dc1;
  logic [1:0]  dc2;

  int passed = 0;
  int total  = 0;

  int depth [3] = '{2, 3, 2};
  int dmax  [3] = '{65535, 65535, 3};
  logic [7:0] mq [3][$];
  int mdrop [3] = '{0, 0, 0};

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .stall(stall),
    .flush(flush), .count(cn[0]), .drop_cnt(dc0));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .stall(stall),
    .flush(flush), .count(cn[1]), .drop_cnt(dc1));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .stall(stall),
    .flush(flush), .count(cn[2]), .drop_cnt(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] drop_obs(input int i);
    if (i == 0) return 32'(dc0);
    if (i == 1) return 32'(dc1);
    return 32'(dc2);
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int sz = mq[i].size();
      check($sformatf("count%0d", i), 32'(cn[i]), 32'(sz));
      check($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(sz != 0));
      check($sformatf("out_data%0d", i), 32'(od[i]), (sz != 0) ? 32'(mq[i][0]) : 32'd0);
      check($sformatf("in_ready%0d", i), 32'(ir[i]), 32'((sz < depth[i]) && !stall));
      check($sformatf("drop_cnt%0d", i), drop_obs(i), 32'(mdrop[i]));
    end
  endtask

  // Queue model: occupancy is the queue length, head is element 0.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int sz = mq[i].size();
      if (reset) begin
        mq[i].delete();
        mdrop[i] = 0;
      end else if (flush) begin
        mdrop[i] = (mdrop[i] + sz > dmax[i]) ? dmax[i] : mdrop[i] + sz;
        mq[i].delete();
      end else if (!stall) begin
        bit take = in_valid && (sz < depth[i]);
        if (out_ready && sz > 0) void'(mq[i].pop_front());
        if (take) mq[i].push_back(in_data);
      end
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [7:0] id,
                      input logic ordy, input logic st, input logic fl, input bit chk);
    reset = rst; in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
    #1;
    if (chk) check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset with in_valid held
    step(1, 1, 8'h55, 0, 0, 0, 0);
    step(1, 1, 8'h55, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    check("rst_count", 32'(cn[0]), 32'd0);
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    check("rst_out_data", 32'(od[0]), 32'd0);

    // First push visible one cycle later
    step(0, 1, 8'hA5, 0, 0, 0, 1);
    check("first_valid", 32'(ov[0]), 32'd1);
    check("first_data", 32'(od[0]), 32'hA5);
    step(0, 0, 8'h00, 1, 0, 0, 1);
    step(0, 0, 8'h00, 1, 0, 0, 1);

    // Back-to-back streaming
    for (int k = 1; k <= 8; k++) step(0, 1, 8'(k), 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 1, 0, 0, 1);

    // Fill to capacity, overflow held off, then drain across pointer wrap
    for (int k = 0; k < 4; k++) step(0, 1, 8'(8'h10 + k), 0, 0, 0, 1);
    check("d3_full_ready", 32'(ir[1]), 32'd0);
    check("d3_full_count", 32'(cn[1]), 32'd3);
    step(0, 1, 8'h13, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 8'h00, 1, 0, 0, 1);

    // Stall freezes both ends
    step(0, 1, 8'h20, 0, 0, 0, 1);
    step(0, 1, 8'h21, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 8'h22, 1, 1, 0, 1);
    check("stall_count", 32'(cn[0]), 32'd2);
    check("stall_data", 32'(od[0]), 32'h20);
    check("stall_ready", 32'(ir[0]), 32'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 8'h00, 1, 0, 0, 1);

    // Flush with stall and a push: everything discarded
    step(0, 1, 8'h30, 0, 0, 0, 1);
    step(0, 1, 8'h31, 0, 0, 0, 1);
    step(0, 1, 8'h77, 1, 1, 1, 1);
    check("flush_count", 32'(cn[0]), 32'd0);
    check("flush_valid", 32'(ov[0]), 32'd0);
    check("flush_drop", 32'(dc0), 32'd2);
    for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 1, 0, 0, 1);

    // Drop counter saturation on the narrow-counter instance
    step(1, 0, 8'h00, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      step(0, 1, 8'(8'h40 + 2 * r), 0, 0, 0, 1);
      step(0, 1, 8'(8'h41 + 2 * r), 0, 0, 0, 1);
      step(0, 0, 8'h00, 0, 0, 1, 1);
    end
    check("sat_drop_c2", 32'(dc2), 32'd3);
    check("sat_drop_d2", 32'(dc0), 32'd6);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0),
           1);
    end
    step(0, 0, 8'h00, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
